// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, op encodings, FSM state type and op-decode
// helpers for the EX-stage iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int XLEN     = 32;
  localparam int TAG_W    = 5;
  localparam int ITER_CNT = 32;
  localparam int CNT_W    = $clog2(ITER_CNT);

  localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 is treated as signed by MULH, MULHSU, DIV, REM.
  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as signed by MULH, DIV, REM.
  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// muldiv_iter_dp: one radix-2 step per cycle on unsigned magnitudes.
//   Multiply: shift-add, accumulator {hi,lo} starts as {0, a}; after XLEN
//             steps it holds the full 2*XLEN product a*b.
//   Divide:   restoring, accumulator {rem,quot} starts as {0, a}; after
//             XLEN steps hi = remainder, lo = quotient of a/b.
// Ports:
//   clk, reset_n  clock, async active-low reset
//   i_load        load magnitudes i_a/i_b, clear high half
//   i_step        perform one iteration
//   i_is_div      select divide step (else multiply step)
//   i_a, i_b      operand magnitudes
//   o_acc         accumulator (product, or {remainder, quotient})
module muldiv_iter_dp
  import muldiv_pkg::*;
#(
  parameter int DW = XLEN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_is_div,
  input  logic [DW-1:0]   i_a,
  input  logic [DW-1:0]   i_b,
  output logic [2*DW-1:0] o_acc
);

  logic [2*DW-1:0] r_acc;
  logic [DW-1:0]   r_b;
  logic [DW:0]     w_sum;
  logic [DW:0]     w_trial;
  logic [2*DW-1:0] w_next;

  always_comb begin
    // Multiply: conditionally add multiplicand to high half, then shift the
    // 65-bit {carry, hi, lo} right by one.
    w_sum   = {1'b0, r_acc[2*DW-1:DW]} + (r_acc[0] ? {1'b0, r_b} : '0);
    // Divide: {rem, next dividend bit} minus divisor; borrow means restore.
    w_trial = r_acc[2*DW-1:DW-1] - {1'b0, r_b};
    w_next  = r_acc;
    if (i_is_div) begin
      if (!w_trial[DW])
        w_next = {w_trial[DW-1:0], r_acc[DW-2:0], 1'b1};
      else
        w_next = {r_acc[2*DW-2:0], 1'b0};
    end else begin
      w_next = {w_sum, r_acc[DW-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
      r_b   <= '0;
    end else if (i_load) begin
      r_acc <= {{DW{1'b0}}, i_a};
      r_b   <= i_b;
    end else if (i_step) begin
      r_acc <= w_next;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: iterative RV32M multiply/divide sequencer beside the EX ALU.
// Accepts an M-op in IDLE, runs 32 radix-2 steps, applies sign correction,
// then presents result/rd_out with a one-cycle done pulse. Fixed latency:
// done in the 34th cycle after the accept cycle.
// Build option: define MULDIV_EARLY_OUT_EN to send divide-by-zero, signed
// overflow and multiply-by-zero straight from IDLE to FIX (done in cycle 2).
// Ports:
//   clk, reset_n  clock, async active-low reset
//   start         valid M-op in EX this cycle
//   op            0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   rs1, rs2      operands
//   rd_in         destination tag
//   flush         synchronous abort, wins over start
//   stall_req     hold IF/ID/EX
//   busy          state != IDLE
//   done          one-cycle result-valid pulse
//   result        registered result
//   rd_out        registered destination tag
module ex_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = muldiv_pkg::XLEN,
  parameter int TAG_W = muldiv_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [TAG_W-1:0] rd_in,
  input  logic             flush,
  output logic             stall_req,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] rd_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CNT - 1);

  state_t r_state, w_next;

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [TAG_W-1:0] r_rd;
  logic [XLEN-1:0]  r_rs1;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic             r_ovf;
  logic             r_mzero;
  logic [XLEN-1:0]  r_result;
  logic [TAG_W-1:0] r_rd_out;
  logic             r_done;

  logic             w_load, w_step, w_fix;
  logic             w_is_div, w_sa, w_sb;
  logic [XLEN-1:0]  w_abs_a, w_abs_b;
  logic             w_div0, w_ovf, w_mzero;
  logic [2*XLEN-1:0] w_acc, w_prod;
  logic [XLEN-1:0]  w_quot, w_rem, w_fix_res;

  // Operand decode in the accept cycle.
  always_comb begin
    w_is_div = op_is_div(op);
    w_sa     = op_a_signed(op) & rs1[XLEN-1];
    w_sb     = op_b_signed(op) & rs2[XLEN-1];
    w_abs_a  = w_sa ? -rs1 : rs1;
    w_abs_b  = w_sb ? -rs2 : rs2;
    w_div0   = w_is_div & (rs2 == '0);
    w_ovf    = w_is_div & op_b_signed(op) & (rs1 == INT_MIN) & (rs2 == '1);
    w_mzero  = !w_is_div & ((rs1 == '0) | (rs2 == '0));
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_fix  = 1'b0;
    if (flush) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_load = 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
            w_next = (w_div0 | w_ovf | w_mzero) ? ST_FIX : ST_RUN;
`else
            w_next = ST_RUN;
`endif
          end
        end
        ST_RUN: begin
          w_step = 1'b1;
          if (r_cnt == CNT_LAST) w_next = ST_FIX;
        end
        ST_FIX: begin
          w_fix  = 1'b1;
          w_next = ST_DONE;
        end
        ST_DONE: w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_rd     <= '0;
      r_rs1    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_mzero  <= 1'b0;
      r_result <= '0;
      r_rd_out <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_fix;
      if (w_load) begin
        r_cnt   <= '0;
        r_op    <= op;
        r_rd    <= rd_in;
        r_rs1   <= rs1;
        r_neg_q <= w_sa ^ w_sb;
        r_neg_r <= w_sa;
        r_div0  <= w_div0;
        r_ovf   <= w_ovf;
        r_mzero <= w_mzero;
      end else if (w_step) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_fix) begin
        r_result <= w_fix_res;
        r_rd_out <= r_rd;
      end
    end
  end

  muldiv_iter_dp #(.DW(XLEN)) u_dp (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_is_div (op_is_div(r_op)),
    .i_a      (w_abs_a),
    .i_b      (w_abs_b),
    .o_acc    (w_acc)
  );

  // Special cases are resolved here explicitly so the early-out path, which
  // never ran the datapath, yields the same values as the full iteration.
  always_comb begin
    w_prod = r_neg_q ? -w_acc : w_acc;
    w_quot = r_neg_q ? -w_acc[XLEN-1:0] : w_acc[XLEN-1:0];
    w_rem  = r_neg_r ? -w_acc[2*XLEN-1:XLEN] : w_acc[2*XLEN-1:XLEN];
    if (r_div0) begin
      w_quot = DIV0_QUOT;
      w_rem  = r_rs1;
    end else if (r_ovf) begin
      w_quot = INT_MIN;
      w_rem  = '0;
    end
    case (r_op)
      OP_MUL:                     w_fix_res = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:            w_fix_res = w_quot;
      default:                    w_fix_res = w_rem;
    endcase
    if (r_mzero) w_fix_res = '0;
  end

  assign stall_req = ((r_state == ST_IDLE) & start & !flush) |
                     (r_state == ST_RUN) | (r_state == ST_FIX);
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign result    = r_result;
  assign rd_out    = r_rd_out;

endmodule

// File: doc/ex_muldiv_seq.md
Name: ex_muldiv_seq

Overview:
Iterative multiply/divide sequencer attached beside the EX stage ALU; executes RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) over multiple cycles. Holds the pipeline with stall_req while busy, then presents result plus destination tag for one cycle so EX/MEM latches it like a normal ALU result. Honours pipeline flush.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
TAG_W, 5, destination register tag width

Ports:
clk  in  1  clock
reset_n  in  1  async active-low reset
start  in  1  valid M-op in EX this cycle
op  in  3  0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
rs1  in  XLEN  operand A (forwarded value)
rs2  in  XLEN  operand B
rd_in  in  TAG_W  destination tag
flush  in  1  synchronous abort (branch/exception)
stall_req  out  1  hold IF/ID/EX
busy  out  1  state != IDLE
done  out  1  one-cycle result-valid pulse
result  out  XLEN  registered result
rd_out  out  TAG_W  registered tag

Behaviour:
- Reset reset_n, asynchronous, active-low; clock clk. On reset: state IDLE, done 0, result 0, rd_out 0, counter 0, busy 0.
- States: IDLE, RUN, FIX, DONE.
- IDLE: start & !flush at edge E0 -> latch op, rd_in, |rs1|,|rs2| per signedness (MULHSU: rs1 signed, rs2 unsigned; *U ops unsigned), result-sign flags; count=0; -> RUN.
- RUN: one radix-2 step per edge; MUL: shift-add into 64-bit product; DIV: restoring, 32-bit remainder/quotient. Edges E1..E32; count==31 at step -> FIX.
- FIX (edge E33): apply sign correction (two's-complement negate), select low/high product, quotient or remainder; write result, rd_out; -> DONE.
- DONE: done=1 for exactly one cycle; -> IDLE at E34. Start in DONE cycle ignored (pipeline sees stall low, next instruction arrives next cycle).
- Fixed latency: done high in cycle 34 after accept cycle.
- stall_req = (IDLE & start & !flush) | RUN | FIX. Low in DONE and idle.
- Div by zero: quotient 0xFFFFFFFF (DIV & DIVU), remainder = rs1. Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. No traps.
- Remainder sign follows dividend; quotient sign = sign(A) xor sign(B) (signed ops only).
- flush in any state: next state IDLE, done not asserted, result/rd_out keep previous values; flush with start same cycle: flush wins, nothing accepted.
- start while RUN/FIX: ignored, latched operands unaffected.
- Reset mid-operation: immediate return to reset values, no done.

Optional Feature:
MULDIV_EARLY_OUT_EN: when defined, div-by-zero, signed overflow, and multiply with either operand zero skip RUN: IDLE -> FIX at E0, done in cycle 2 after accept (stall_req covers IDLE-accept and FIX only). When undefined, all ops take fixed 34-cycle latency, special cases resolved in FIX.

Decomposition:
- Package muldiv_pkg: XLEN, op encodings (OP_MUL..OP_REMU), state enum (ST_IDLE, ST_RUN, ST_FIX, ST_DONE), ITER_CNT=32, DIV0_QUOT=32'hFFFFFFFF.
- One natural sub-module: muldiv_iter_dp (step datapath: product/remainder shift registers, add/sub step); FSM, counter, sign fix stay in top.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), rd=5 -> stall 34 cycles, done pulse cycle 34, result 0xFFFFFFEB, rd_out 5.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIVU 0x1234/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; with MULDIV_EARLY_OUT_EN done in cycle 2.
- flush at cycle 10 of DIV -> busy 0 next cycle, no done, result unchanged; new MUL 3*4 started next cycle -> result 12.
- reset_n low during RUN -> done 0, result 0, stall_req 0 immediately; start+flush same cycle -> stays IDLE.
